// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared states, instruction classes, pc_src codes and opcode constants
package multicycle_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_FAULT  = 3'b111
  } state_t;
  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JAL, C_JR, C_ILLEGAL
  } insn_class_t;
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;
  localparam int OP_RTYPE  = 0;
  localparam int OP_REGIMM = 1;
  localparam int OP_J      = 2;
  localparam int OP_JAL    = 3;
  localparam int OP_BEQ    = 4;
  localparam int OP_BNE    = 5;
  localparam int OP_ANDI   = 12;
  localparam int OP_ORI    = 13;
  localparam int OP_LUI    = 15;
  localparam int OP_LW     = 35;
  localparam int OP_SW     = 43;
  localparam int FN_JR     = 8;
  function automatic logic is_alu_funct(input int f);
    return f inside {29, 30, 31, 32, 34, 36, 37, 38, 42};
  endfunction
endpackage

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: instruction/handshake inputs and datapath strobes of the control FSM
interface multicycle_control_fsm_if #(
  parameter int OPC_W = 6,
  parameter int FN_W  = 6,
  parameter int CNT_W = 32
);
  logic [OPC_W-1:0] opcode;
  logic [FN_W-1:0]  function_val;
  logic             imem_ready;
  logic             dmem_ready;
  logic             branch_taken;
  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             alu_start;
  logic             dmem_read;
  logic             dmem_write;
  logic             reg_write;
  logic             fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] insn_count;
  modport master (
    input  opcode, function_val, imem_ready, dmem_ready, branch_taken,
    output imem_req, ir_write, pc_write, pc_src, alu_start, dmem_read, dmem_write,
           reg_write, fault, state, insn_count
  );
  modport slave (
    output opcode, function_val, imem_ready, dmem_ready, branch_taken,
    input  imem_req, ir_write, pc_write, pc_src, alu_start, dmem_read, dmem_write,
           reg_write, fault, state, insn_count
  );
endinterface

// File: rtl/insn_class_decoder.sv
// insn_class_decoder: combinational opcode/function to instruction class
module insn_class_decoder
  import multicycle_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int FN_W  = 6
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [FN_W-1:0]  function_val,
  output insn_class_t      cls
);
  int op;
  int fn;
  always_comb begin
    op  = int'(opcode);
    fn  = int'(function_val);
    cls = C_ILLEGAL;
    case (op)
      OP_RTYPE: cls = is_alu_funct(fn) ? C_ALU : fn == FN_JR ? C_JR : C_ILLEGAL;
      OP_ANDI, OP_ORI, OP_LUI: cls = C_ALU;
      OP_LW: cls = C_LOAD;
      OP_SW: cls = C_STORE;
      OP_REGIMM, OP_BEQ, OP_BNE: cls = C_BRANCH;
      OP_J: cls = C_JUMP;
      OP_JAL: cls = C_JAL;
      default: cls = C_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer with ready timeouts, fault and retire counter
module multicycle_control_fsm
  import multicycle_pkg::*;
#(
  parameter int OPC_W       = 6,
  parameter int FN_W        = 6,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  multicycle_control_fsm_if.master bus
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  state_t           state_q, state_d;
  insn_class_t      cls_q, cls_d, dec_cls;
  logic [WC_W-1:0]  wait_q;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic             timeout;
  insn_class_decoder #(.OPC_W(OPC_W), .FN_W(FN_W)) u_dec (
    .opcode       (bus.opcode),
    .function_val (bus.function_val),
    .cls          (dec_cls)
  );
  assign timeout        = wait_q == WC_W'(MEM_TIMEOUT - 1);
  assign bus.fault      = state_q == S_FAULT;
  assign bus.state      = state_q;
  assign bus.insn_count = count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_ALU;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= (state_d != state_q) ? '0 : (state_q == S_FETCH || state_q == S_MEM) ? wait_q + WC_W'(1) : '0;
      count_q <= count_q + CNT_W'(retire);
    end
  always_comb begin
    state_d        = state_q;
    cls_d          = cls_q;
    retire         = 1'b0;
    bus.imem_req   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = PC_PLUS4;
    bus.alu_start  = 1'b0;
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    bus.reg_write  = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_write = bus.imem_ready;
        bus.pc_write = bus.imem_ready;
        state_d      = bus.imem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        state_d = dec_cls == C_ILLEGAL ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        bus.alu_start = cls_q inside {C_ALU, C_LOAD, C_STORE};
        bus.pc_write  = (cls_q == C_BRANCH && bus.branch_taken) || cls_q inside {C_JUMP, C_JAL, C_JR};
        bus.pc_src    = (cls_q == C_BRANCH && bus.branch_taken) ? PC_BRANCH :
                        cls_q == C_JR ? PC_REG :
                        cls_q inside {C_JUMP, C_JAL} ? PC_JUMP : PC_PLUS4;
        bus.reg_write = cls_q == C_JAL;
        state_d       = cls_q == C_ALU ? S_WB :
                        cls_q inside {C_LOAD, C_STORE} ? S_MEM :
                        cls_q == C_ILLEGAL ? S_FAULT : S_FETCH;
        retire        = cls_q inside {C_BRANCH, C_JUMP, C_JAL, C_JR};
      end
      S_MEM: begin
        bus.dmem_read  = cls_q == C_LOAD;
        bus.dmem_write = cls_q == C_STORE;
        state_d        = bus.dmem_ready ? (cls_q == C_LOAD ? S_WB : S_FETCH) : timeout ? S_FAULT : S_MEM;
        retire         = bus.dmem_ready && cls_q == C_STORE;
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed checks of sequencing, strobes, timeouts, fault and reset
module tb_multicycle_control_fsm;
  logic clk;
  logic rst;
  int checks = 0;
  int errors = 0;
  multicycle_control_fsm_if #(.OPC_W(6), .FN_W(6), .CNT_W(32)) bus ();
  multicycle_control_fsm #(.OPC_W(6), .FN_W(6), .CNT_W(32), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.opcode = 6'd0;
    bus.function_val = 6'd32;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b1;
    bus.branch_taken = 1'b0;
    #12;
    check("rst_state", bus.state, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_count", bus.insn_count, 0);
    check("rst_strobes", {bus.ir_write, bus.pc_write, bus.reg_write, bus.alu_start, bus.dmem_read, bus.dmem_write}, 0);
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    #1;
    check("alu_fetch", {bus.state, bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src}, {3'd0, 3'b111, 2'b00});
    tick;
    check("alu_decode", {bus.state, bus.reg_write, bus.ir_write}, {3'd1, 2'b00});
    tick;
    check("alu_exec", {bus.state, bus.alu_start, bus.reg_write}, {3'd2, 2'b10});
    tick;
    check("alu_wb", {bus.state, bus.reg_write, bus.insn_count}, {3'd4, 1'b1, 32'd0});
    tick;
    check("alu_retire", {bus.state, bus.reg_write, bus.insn_count}, {3'd0, 1'b0, 32'd1});
    bus.opcode = 6'd35;
    bus.dmem_ready = 1'b0;
    tick;
    tick;
    check("lw_exec", {bus.state, bus.alu_start}, {3'd2, 1'b1});
    tick;
    for (int i = 0; i < 3; i++) begin
      check("lw_mem_wait", {bus.state, bus.dmem_read, bus.dmem_write, bus.reg_write}, {3'd3, 3'b100});
      tick;
    end
    bus.dmem_ready = 1'b1;
    #1;
    check("lw_mem_ready", {bus.state, bus.dmem_read}, {3'd3, 1'b1});
    tick;
    check("lw_wb", {bus.state, bus.reg_write, bus.dmem_read, bus.insn_count}, {3'd4, 2'b10, 32'd1});
    tick;
    check("lw_retire", {bus.state, bus.fault, bus.insn_count}, {3'd0, 1'b0, 32'd2});
    bus.opcode = 6'd4;
    bus.branch_taken = 1'b1;
    tick;
    tick;
    check("beq_taken", {bus.state, bus.pc_write, bus.pc_src, bus.alu_start}, {3'd2, 1'b1, 2'b01, 1'b0});
    tick;
    check("beq_taken_ret", {bus.state, bus.insn_count}, {3'd0, 32'd3});
    bus.branch_taken = 1'b0;
    tick;
    tick;
    check("beq_not_taken", {bus.state, bus.pc_write}, {3'd2, 1'b0});
    tick;
    check("beq_nt_ret", {bus.state, bus.insn_count}, {3'd0, 32'd4});
    bus.opcode = 6'd0;
    bus.function_val = 6'd8;
    tick;
    tick;
    check("jr_exec", {bus.pc_write, bus.pc_src, bus.reg_write}, 4'b1110);
    tick;
    check("jr_ret", {bus.state, bus.insn_count}, {3'd0, 32'd5});
    bus.opcode = 6'd3;
    tick;
    tick;
    check("jal_exec", {bus.pc_write, bus.pc_src, bus.reg_write}, 4'b1101);
    tick;
    check("jal_ret", {bus.state, bus.insn_count}, {3'd0, 32'd6});
    bus.opcode = 6'd43;
    tick;
    tick;
    tick;
    check("sw_mem", {bus.state, bus.dmem_write, bus.dmem_read}, {3'd3, 2'b10});
    tick;
    check("sw_ret", {bus.state, bus.insn_count}, {3'd0, 32'd7});
    bus.opcode = 6'd16;
    tick;
    check("ill_decode", bus.state, 1);
    tick;
    check("ill_fault", {bus.state, bus.fault}, {3'd7, 1'b1});
    check("ill_strobes", {bus.imem_req, bus.ir_write, bus.pc_write, bus.alu_start, bus.dmem_read, bus.dmem_write, bus.reg_write}, 0);
    tick;
    tick;
    check("ill_sticky", {bus.state, bus.fault, bus.insn_count}, {3'd7, 1'b1, 32'd7});
    rst = 1'b1;
    #1;
    check("ill_rst", {bus.state, bus.fault, bus.insn_count}, {3'd0, 1'b0, 32'd0});
    rst = 1'b0;
    bus.imem_ready = 1'b0;
    repeat (14) tick;
    check("if_wait14", {bus.state, bus.fault}, {3'd0, 1'b0});
    tick;
    check("if_timeout", {bus.state, bus.fault}, {3'd7, 1'b1});
    rst = 1'b1;
    #1;
    rst = 1'b0;
    repeat (14) tick;
    bus.imem_ready = 1'b1;
    bus.opcode = 6'd35;
    bus.dmem_ready = 1'b0;
    #1;
    check("if_ready_last", {bus.state, bus.ir_write}, {3'd0, 1'b1});
    tick;
    check("if_ready_wins", {bus.state, bus.fault}, {3'd1, 1'b0});
    tick;
    tick;
    check("mid_mem", bus.state, 3);
    rst = 1'b1;
    #1;
    check("mid_mem_rst", {bus.state, bus.insn_count, bus.dmem_read}, {3'd0, 32'd0, 1'b0});
    rst = 1'b0;
    tick;
    tick;
    tick;
    repeat (14) tick;
    check("mem_wait14", {bus.state, bus.dmem_read}, {3'd3, 1'b1});
    tick;
    check("mem_timeout", {bus.state, bus.fault, bus.insn_count}, {3'd7, 1'b1, 32'd0});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequential successor to the combinational instruction decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives per-state strobes for the program counter, instruction register, register file, ALU and data memory.
- Adds memory-ready handshakes, a wait timeout, an illegal-instruction fault and a retired-instruction counter.
- Sits between the instruction register/decoder and the datapath of the multicycle core.

Parameters:
OPC_W, 6, opcode field width
FN_W, 6, function field width
CNT_W, 32, retired-instruction counter width
MEM_TIMEOUT, 15, max cycles waiting for imem_ready/dmem_ready before FAULT (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  OPC_W  opcode of instruction register, sampled in DECODE only
function_val  in  FN_W  function field, sampled in DECODE only
imem_ready  in  1  instruction memory returns word this cycle
dmem_ready  in  1  data memory completes access this cycle
branch_taken  in  1  ALU compare result, valid in EXEC
imem_req  out  1  instruction fetch request
ir_write  out  1  load instruction register
pc_write  out  1  update PC
pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 register (jr)
alu_start  out  1  ALU operate strobe
dmem_read  out  1  data read request
dmem_write  out  1  data write request
reg_write  out  1  register-file write strobe
fault  out  1  sticky fault flag
state  out  3  current state encoding
insn_count  out  CNT_W  retired instructions

Behaviour:
- Async reset:
  - state=FETCH(000), all strobes 0, fault=0, insn_count=0, wait counter=0, class register=ALU.
  - Reset mid-instruction abandons the instruction with no retire.
- State encodings: FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, FAULT 111. Other codes go to FAULT next cycle.
- Strobes are combinational from state, latched class, branch_taken and ready inputs. There are no outputs from inputs other than these.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_write=1, pc_write=1, pc_src=00, next DECODE.
  - Otherwise the wait counter increments. When the counter reaches MEM_TIMEOUT without ready, next FAULT.
- DECODE:
  - Latch class from opcode/function_val. No strobes. ILLEGAL goes to FAULT, else EXEC.
  - Classes:
    - opcode 0, funct in {29,30,31,32,34,36,37,38,42}: ALU.
    - opcode 0, funct 8: JR.
    - opcode 0, other funct: ILLEGAL.
    - opcode 12, 13, 15: ALU (immediate).
    - opcode 35: LOAD. opcode 43: STORE.
    - opcode 1, 4, 5: BRANCH. opcode 2: JUMP. opcode 3: JAL.
    - All other opcodes: ILLEGAL.
- EXEC:
  - ALU: alu_start=1, next WB.
  - LOAD/STORE: alu_start=1 (address calculation), next MEM.
  - BRANCH: if branch_taken then pc_write=1, pc_src=01. Retire, next FETCH.
  - JUMP: pc_write=1, pc_src=10. Retire, next FETCH.
  - JAL: pc_write=1, pc_src=10, reg_write=1 (link). Retire, next FETCH.
  - JR: pc_write=1, pc_src=11. Retire, next FETCH.
- MEM:
  - dmem_read (LOAD) or dmem_write (STORE) held high until dmem_ready.
  - On ready: STORE retires and goes to FETCH; LOAD goes to WB.
  - Timeout rule is identical to FETCH.
- WB: reg_write=1 for one cycle. Retire, next FETCH.
- Wait counter clears on every state change.
- Ready arriving in the same cycle the counter hits MEM_TIMEOUT counts as success (ready wins).
- Retire means insn_count+1 on that clock edge. insn_count wraps modulo 2^CNT_W.
- FAULT: all strobes 0, fault=1. Leave only via rst.
- Cycle counts with zero-wait memory: ALU 4, LOAD 5, STORE 4, BRANCH/JUMP/JAL/JR 3.

Decomposition:
- Package multicycle_pkg:
  - state enum/localparams.
  - pc_src codes.
  - class enum (ALU, LOAD, STORE, BRANCH, JUMP, JAL, JR, ILLEGAL).
  - opcode/funct constants.
- Sub-module insn_class_decoder: purely combinational opcode/function_val to class.
- FSM, wait counter and insn_count stay in the top module.

Test Plan:
- rst=1 then release; opcode=0, funct=32, ready always 1 -> states 000,001,010,100,000; reg_write high only in WB; insn_count=1 after 4 cycles.
- opcode=35, dmem_ready held 0 for 3 cycles then 1 -> dmem_read high 4 cycles in MEM, then WB reg_write; insn_count increments once; no fault.
- opcode=4 with branch_taken=1, then again with branch_taken=0 -> first: pc_write=1, pc_src=01 in EXEC; second: pc_write=0 in EXEC; both retire in 3 cycles.
- opcode=0, funct=8 -> pc_src=11 in EXEC. opcode=3 -> pc_src=10 and reg_write=1 in the same EXEC cycle.
- opcode=16 (or opcode 0, funct 0) -> DECODE then FAULT; fault=1, all strobes 0 and held there; rst clears to FETCH with count 0.
- imem_ready=0 for MEM_TIMEOUT cycles -> FAULT. Repeat with ready arriving exactly on the MEM_TIMEOUT cycle -> DECODE, no fault. Assert rst mid-MEM -> state 000 immediately, count unchanged.
